// File: rtl/input_pulse_cond_if.sv
// Bundle of the conditioner's data signals: the raw button/contact input
// going in and the debounced level, press strobe and repeat flag coming out.
interface input_pulse_cond_if;
  logic raw_in;
  logic x_pulse;
  logic x_level;
  logic rpt_active;

  // Driver side: owns the raw input, observes the conditioned outputs.
  modport master (
    output raw_in,
    input  x_pulse,
    input  x_level,
    input  rpt_active
  );

  // Conditioner side.
  modport slave (
    input  raw_in,
    output x_pulse,
    output x_level,
    output rpt_active
  );
endinterface

// File: rtl/input_pulse_cond.sv
// input_pulse_cond: synchronizes and debounces an asynchronous input,
// producing a debounced level and a one-cycle strobe per accepted press.
// Build option: define AUTO_REPEAT_EN to add held-key auto-repeat pulses;
// without it rpt_active is tied low and each press gives exactly one pulse.
module input_pulse_cond #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8,
  parameter int HOLD_CYCLES     = 20,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input_pulse_cond_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter values the counters cannot represent.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_db_range
    $error("DEBOUNCE_CYCLES out of range for CNT_W");
  end
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_rpt_range
    $error("HOLD_CYCLES and REPEAT_CYCLES must be at least 1");
  end

  logic             r_sync1;
  logic             r_sync2;
  logic             w_sync_in;
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_accept;
  logic             w_rpt_fire;
  logic             r_pend;
  logic             r_x_pulse;
  logic             r_x_level;

  assign w_sync_in = r_sync2;
  // Saturating increment so a long-lived count never wraps back to zero.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  // Two-flop synchronizer: the only place raw_in is sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce state and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic: a change must be seen steadily before it is accepted.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sync_in) begin
          w_state_next = PRESS_CHK;
          w_cnt_next   = '0;
        end
      end
      PRESS_CHK: begin
        if (!w_sync_in) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_next = HELD;
          w_cnt_next   = '0;
          w_accept     = 1'b1;
        end else begin
          w_cnt_next   = w_cnt_inc;
        end
      end
      HELD: begin
        if (!w_sync_in) begin
          w_state_next = REL_CHK;
          w_cnt_next   = '0;
        end
      end
      REL_CHK: begin
        if (w_sync_in) begin
          w_state_next = HELD;
          w_cnt_next   = '0;
        end else if (r_cnt == DB_LAST) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = w_cnt_inc;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] r_rpt_cnt;
  logic             r_rpt_on;
  logic             r_rpt_active;

  // First repeat waits the hold time, later ones use the shorter spacing.
  assign w_rpt_fire = (r_state == HELD) && (w_state_next == HELD) &&
                      (r_rpt_cnt == (r_rpt_on ? REP_LAST : HOLD_LAST));

  // Repeat timer: restarts on every HELD entry, runs only while HELD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rpt_cnt    <= '0;
      r_rpt_on     <= 1'b0;
      r_rpt_active <= 1'b0;
    end else begin
      r_rpt_active <= r_rpt_on;
      if (w_state_next != HELD || r_state != HELD) begin
        r_rpt_cnt <= '0;
        r_rpt_on  <= 1'b0;
      end else if (w_rpt_fire) begin
        r_rpt_cnt <= '0;
        r_rpt_on  <= 1'b1;
      end else if (r_rpt_cnt != CNT_MAX) begin
        r_rpt_cnt <= r_rpt_cnt + 1'b1;
      end
    end
  end

  assign bus.rpt_active = r_rpt_active;
`else
  assign w_rpt_fire     = 1'b0;
  assign bus.rpt_active = 1'b0;
`endif

  // Output registers: pulse is staged once so it lines up with x_level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend    <= 1'b0;
      r_x_pulse <= 1'b0;
      r_x_level <= 1'b0;
    end else begin
      r_pend    <= w_accept | w_rpt_fire;
      r_x_pulse <= r_pend;
      r_x_level <= (r_state == HELD) || (r_state == REL_CHK);
    end
  end

  assign bus.x_pulse = r_x_pulse;
  assign bus.x_level = r_x_level;

endmodule

// File: tb/tb_input_pulse_cond.sv
// Directed bench for input_pulse_cond at DEBOUNCE_CYCLES=4, HOLD_CYCLES=20,
// REPEAT_CYCLES=8. Cycle n of a vector = the n-th rising edge after the
// vector starts; outputs are sampled on the following falling edge.
module tb_input_pulse_cond;

  logic clk;
  logic rst;
  input_pulse_cond_if bus ();

  input_pulse_cond #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(8),
    .HOLD_CYCLES(20),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic check_outs_zero(input string name);
    check_eq({name, "_x_pulse"}, int'(bus.x_pulse === 1'b0), 1);
    check_eq({name, "_x_level"}, int'(bus.x_level === 1'b0), 1);
    check_eq({name, "_rpt"},     int'(bus.rpt_active === 1'b0), 1);
  endtask

  typedef struct {
    logic [31:0] pattern;       // bit n = raw_in for cycle n
    int          exp_pulses;
    int          exp_first_pulse;
    int          exp_level_cnt;
    int          exp_level_first;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [31:0] pat;
    int pcnt, pfirst, lcnt, lfirst, rcnt, b2b;
    logic prev_p;
    int pq[$];
    int exp_q[$];
    int exp_rpt_first, exp_rpt_cnt, rfirst;

    // pattern, pulses, first pulse, level cycles, first level cycle
    vecs[0] = '{32'h0000_7FFF, 1,  7, 15,  7};  // 15-cycle press
    vecs[1] = '{32'h0000_0003, 0, -1,  0, -1};  // 2-cycle glitch
    vecs[2] = '{32'h0000_0018, 0, -1,  0, -1};  // 2-cycle glitch, later phase
    vecs[3] = '{32'h0000_000F, 0, -1,  0, -1};  // 4 cycles: one short
    vecs[4] = '{32'h0000_001F, 1,  7,  5,  7};  // 5 cycles: shortest accepted
    vecs[5] = '{32'h001F_FBFF, 1,  7, 21,  7};  // 1-cycle dropout while held
    vecs[6] = '{32'h0000_1FFB, 1, 10, 10, 10};  // press bounce then press
    vecs[7] = '{32'h01FF_83FF, 2,  7, 20,  7};  // real release then re-press

`ifdef AUTO_REPEAT_EN
    exp_q = '{7, 27, 35, 43, 51};
    exp_rpt_first = 27;
    exp_rpt_cnt   = 26;
`else
    exp_q = '{7};
    exp_rpt_first = -1;
    exp_rpt_cnt   = 0;
`endif

    // Reset pulse low from 2 ns to 6 ns with raw_in low.
    bus.raw_in = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #2 check_outs_zero("rst_during");
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outs_zero("rst_after");

    // Table-driven single-press patterns.
    for (int i = 0; i < 8; i++) begin
      pat = vecs[i].pattern;
      pcnt = 0; pfirst = -1; lcnt = 0; lfirst = -1; rcnt = 0; b2b = 0;
      prev_p = 1'b0;
      for (int c = 0; c < 48; c++) begin
        if (c < 32) bus.raw_in = pat[c];
        else        bus.raw_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (bus.x_pulse === 1'b1) begin
          pcnt++;
          if (pfirst < 0) pfirst = c;
          if (prev_p) b2b++;
        end
        if (bus.x_level === 1'b1) begin
          lcnt++;
          if (lfirst < 0) lfirst = c;
        end
        if (bus.rpt_active === 1'b1) rcnt++;
        prev_p = bus.x_pulse;
      end
      check_eq($sformatf("v%0d_pulses", i), pcnt, vecs[i].exp_pulses);
      check_eq($sformatf("v%0d_first_pulse", i), pfirst, vecs[i].exp_first_pulse);
      check_eq($sformatf("v%0d_level_cycles", i), lcnt, vecs[i].exp_level_cnt);
      check_eq($sformatf("v%0d_level_first", i), lfirst, vecs[i].exp_level_first);
      check_eq($sformatf("v%0d_rpt_cycles", i), rcnt, 0);
      check_eq($sformatf("v%0d_back_to_back", i), b2b, 0);
    end

    // Reset in cycle 5 of a press, raw_in kept high through and after it.
    pcnt = 0;
    bus.raw_in = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.x_pulse === 1'b1) pcnt++;
    end
    check_eq("midrst_pre_pulses", pcnt, 0);
    rst = 1'b0;
    #1 check_outs_zero("midrst_assert");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_outs_zero("midrst_held");
    rst = 1'b1;
    pcnt = 0; pfirst = -1; lfirst = -1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.x_pulse === 1'b1) begin
        pcnt++;
        if (pfirst < 0) pfirst = c;
      end
      if (bus.x_level === 1'b1 && lfirst < 0) lfirst = c;
    end
    check_eq("midrst_post_pulses", pcnt, 1);
    check_eq("midrst_post_first_pulse", pfirst, 7);
    check_eq("midrst_post_level_first", lfirst, 7);
    bus.raw_in = 1'b0;
    repeat (16) @(negedge clk);
    check_eq("midrst_released_level", int'(bus.x_level), 0);

    // Long hold: raw_in high for cycles 0-49.
    pq.delete();
    lcnt = 0; lfirst = -1; rcnt = 0; rfirst = -1; b2b = 0;
    prev_p = 1'b0;
    for (int c = 0; c < 70; c++) begin
      bus.raw_in = (c < 50);
      @(posedge clk);
      @(negedge clk);
      if (bus.x_pulse === 1'b1) begin
        pq.push_back(c);
        if (prev_p) b2b++;
      end
      if (bus.x_level === 1'b1) begin
        lcnt++;
        if (lfirst < 0) lfirst = c;
      end
      if (bus.rpt_active === 1'b1) begin
        rcnt++;
        if (rfirst < 0) rfirst = c;
      end
      prev_p = bus.x_pulse;
    end
    check_eq("hold_pulse_count", pq.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < pq.size()) check_eq($sformatf("hold_pulse%0d_cycle", k), pq[k], exp_q[k]);
    end
    check_eq("hold_level_first", lfirst, 7);
    check_eq("hold_level_cycles", lcnt, 50);
    check_eq("hold_rpt_first", rfirst, exp_rpt_first);
    check_eq("hold_rpt_cycles", rcnt, exp_rpt_cnt);
    check_eq("hold_back_to_back", b2b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_pulse_cond.md
INPUT_PULSE_COND -- requirements
Module: input_pulse_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples needed to accept a level change; legal range 1 to 2^CNT_W-1.
REQ-002 Parameter CNT_W, default 8: width of the debounce and repeat counters.
REQ-003 Parameter HOLD_CYCLES, default 20: cycles in HELD before the first auto-repeat pulse (AUTO_REPEAT_EN builds only).
REQ-004 Parameter REPEAT_CYCLES, default 8: spacing between later auto-repeat pulses (AUTO_REPEAT_EN builds only).
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 raw_in  input  1  asynchronous, possibly bouncing input; it is the only input not already in the clk domain.
REQ-008 x_pulse  output  1  registered one-cycle strobe per accepted press; this is the x_in feed of the downstream counting FSM.
REQ-009 x_level  output  1  registered debounced level of raw_in.
REQ-010 rpt_active  output  1  registered flag, high while auto-repeat is producing pulses.

Function
REQ-011 raw_in SHALL pass through a two-flop synchronizer (reset 0); sync_in is the second flop's output; nothing else in the block samples raw_in.
REQ-012 The FSM SHALL have four states: IDLE, PRESS_CHK, HELD and REL_CHK; any other encoding SHALL go to IDLE on the next edge with all outputs 0.
REQ-013 IDLE: if sync_in=1, go to PRESS_CHK and clear the counter; otherwise stay in IDLE.
REQ-014 PRESS_CHK: if sync_in=0, return to IDLE with no pulse (glitch rejected); otherwise increment the counter.
REQ-015 PRESS_CHK: when sync_in=1 and counter=DEBOUNCE_CYCLES-1, go to HELD, so PRESS_CHK lasts exactly DEBOUNCE_CYCLES cycles.
REQ-016 HELD: if sync_in=0, go to REL_CHK and clear the counter.
REQ-017 REL_CHK: if sync_in=1, return to HELD with no new pulse (release bounce rejected).
REQ-018 REL_CHK: after DEBOUNCE_CYCLES consecutive cycles with sync_in=0, go to IDLE.
REQ-019 x_level SHALL be 1 exactly while the state is HELD or REL_CHK.
REQ-020 x_pulse SHALL be 1 only in the first cycle of each IDLE->PRESS_CHK->HELD entry; a REL_CHK->HELD return SHALL NOT assert it.
REQ-021 Press latency: x_pulse and x_level SHALL rise DEBOUNCE_CYCLES+3 cycles after the first edge that samples raw_in=1.
REQ-022 Release latency: x_level SHALL fall DEBOUNCE_CYCLES+3 cycles after the first edge that samples raw_in=0.
REQ-023 The counter SHALL NOT wrap and SHALL saturate at 2^CNT_W-1.
REQ-024 With DEBOUNCE_CYCLES=1, PRESS_CHK and REL_CHK SHALL each last exactly one cycle.
REQ-025 x_pulse SHALL never be high in two consecutive cycles.

Reset
REQ-026 rst=0 SHALL immediately force the state to IDLE and clear both synchronizer flops and all counters.
REQ-027 rst=0 SHALL immediately force x_pulse, x_level and rpt_active to 0.
REQ-028 A reset during PRESS_CHK, HELD or REL_CHK SHALL discard that operation with no pulse.
REQ-029 After rst rises, a raw_in still high SHALL be debounced again from IDLE.

Configuration
REQ-030 The macro AUTO_REPEAT_EN SHALL compile the auto-repeat logic in or out; the port list SHALL be identical in both builds.
REQ-031 With AUTO_REPEAT_EN: a repeat counter SHALL clear on entry to HELD and on entry to REL_CHK, and count every cycle in HELD.
REQ-032 With AUTO_REPEAT_EN: after HOLD_CYCLES cycles in HELD, x_pulse SHALL fire once more, then every REPEAT_CYCLES cycles while HELD persists.
REQ-033 With AUTO_REPEAT_EN: rpt_active SHALL rise with the first repeat pulse and clear when the state leaves HELD.
REQ-034 Without AUTO_REPEAT_EN: there SHALL be no repeat logic, exactly one pulse per press, and rpt_active tied to 0.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8; cycle 0 = first edge sampling raw_in=1)
REQ-035 Reset pulse low 2-6 ns from time 0 -> all outputs 0 during and after it while raw_in=0.
REQ-036 raw_in=1 for 15 cycles, default build -> x_pulse high in cycle 7 only, x_level 1 from cycle 7 -> x_level 0 seven cycles after release.
REQ-037 raw_in high 2 cycles (any phase) -> no x_pulse and x_level stays 0.
REQ-038 raw_in low 1 cycle during HELD -> x_level stays 1 and no extra pulse.
REQ-039 rst low in cycle 5 of a press with raw_in still high -> no pulse before reset; one pulse 7 cycles after rst rises.
REQ-040 AUTO_REPEAT_EN build, raw_in high cycles 0-49 -> x_pulse in cycles 7, 27, 35, 43 and 51 -> rpt_active 1 from cycle 27 until REL_CHK entry.
